seq_match_display: RTL and testbench
====================================

// Module: seq_match_display
// PURPOSE
// - Parametrised successor of the single-pattern sequence detector: N_SYM one-hot symbol lines, programmable pattern
//   of PAT_LEN symbols, BCD match counter of DIGITS decades with per-digit 7-segment drive, match/overflow/error flags.
// - Top-level datapath block; sits directly behind the input debouncers and drives the on-board display.
// PARAMETERS
// - N_SYM    3             number of symbol input lines (>=2); IDX_W = $clog2(N_SYM)
// - PAT_LEN  3             pattern length in symbols (1..16)
// - PATTERN  {2'd0,2'd1,2'd0}  PAT_LEN*IDX_W bits; PATTERN[IDX_W*k +: IDX_W] = index of k-th symbol, k=0 is oldest (default a,b,a)
// - DIGITS   2             BCD decades in the match counter (1..4)
// PORTS
// - ck    in   1            clock, rising edge
// - rs    in   1            reset, asynchronous, active-low
// - sym   in   N_SYM        one-hot symbol this cycle (bit 0 = a); all-zero = idle
// - clr   in   1            synchronous clear of count and sticky flags
// - p     out  7*DIGITS     segments; p[7*d +: 7] = digit d (d=0 least significant), bit0=seg a .. bit6=seg g, active-high
// - cnt   out  4*DIGITS     BCD match count, cnt[4*d +: 4] = digit d
// - c1    out  1            match pulse, one cycle
// - c2    out  1            sticky counter-overflow flag
// - err   out  1            sticky illegal-symbol flag
// BEHAVIOUR
// - Reset (rs=0, async): history and fill counter cleared, cnt=0, c1=0, c2=0, err=0; p shows "0" on every digit (7'h3F).
// - Each rising edge samples sym:
//   - all-zero: idle, no state change except c1 <= 0.
//   - exactly one bit set: symbol index shifted into a PAT_LEN-deep history; fill = min(fill+1, PAT_LEN).
//   - more than one bit set: illegal; history flushed (fill=0), err <= 1, no match possible this edge.
// - Match: legal symbol sampled at edge t completes the pattern (fill reaches PAT_LEN and history == PATTERN)
//   -> c1=1 for exactly the cycle after edge t; cnt increments at edge t (visible alongside c1).
// - Counter: BCD, each digit 0..9 with carry; at 10^DIGITS-1 a match wraps cnt to 0 and sets c2 (sticky).
// - p is a pure combinational decode of cnt (standard 0-9 glyphs); registered count, no extra latency.
// - clr at edge t: cnt=0, c2=0, err=0; history/fill untouched; a simultaneous match still pulses c1 but cnt stays 0.
// - Simultaneous overflow-match and clr: clr wins, c2 stays 0.
// - Reset mid-pattern: partial history discarded; pattern must be re-entered in full after rs release.
// - PAT_LEN=1: every occurrence of PATTERN[0] is a match.
// CONFIGURATION
// - SEQ_OVERLAP_EN defined: history retained after a match, overlapping matches counted (a,b,a,b,a -> 2 matches).
// - SEQ_OVERLAP_EN undefined: fill cleared to 0 on every match; next match needs PAT_LEN fresh legal symbols
//   (a,b,a,b,a -> 1 match).
// TESTING (defaults: N_SYM=3, PAT_LEN=3, PATTERN=a,b,a, DIGITS=2)
// - Reset: rs=0 -> cnt=8'h00, c1=c2=err=0, p=14'h1FBF (two "0" glyphs, 7'h3F each); release rs -> unchanged.
// - Overlap: a,b,a,b,a -> with SEQ_OVERLAP_EN c1 pulses after 3rd and 5th symbol, cnt=8'h02; without, one pulse, cnt=8'h01.
// - Idle gaps: a,000,b,000,000,a -> one c1 pulse after final a, cnt=8'h01.
// - Illegal: a,b,110,a -> no match, err=1; then b,a,... sequence a,b,a -> match, cnt=8'h01; clr -> cnt=8'h00, err=0.
// - Overflow: 100 matches -> cnt=8'h00 on 100th, c2=1, p=14'h1FBF; match with clr same cycle -> c1=1, cnt=8'h00, c2=0.
// - Reset mid-pattern: a,b, rs pulse low between edges, a -> no c1; a,b,a afterwards -> c1, cnt=8'h01.

Source files
------------

// File: rtl/seq_match_display.sv
// Programmable one-hot symbol sequence detector with BCD match counter and 7-segment drive.
// Optional feature: define SEQ_OVERLAP_EN to keep history after a match so overlapping matches count.
module seq_match_display #(
    parameter int unsigned N_SYM   = 3,
    parameter int unsigned PAT_LEN = 3,
    parameter logic [PAT_LEN*$clog2(N_SYM)-1:0] PATTERN = {2'd0, 2'd1, 2'd0},
    parameter int unsigned DIGITS  = 2
) (
    input  logic                  ck,
    input  logic                  rs,
    input  logic [N_SYM-1:0]      sym,
    input  logic                  clr,
    output logic [7*DIGITS-1:0]   p,
    output logic [4*DIGITS-1:0]   cnt,
    output logic                  c1,
    output logic                  c2,
    output logic                  err
);

    localparam int unsigned IDX_W  = $clog2(N_SYM);
    localparam int unsigned HW     = PAT_LEN * IDX_W;
    localparam int unsigned FILL_W = $clog2(PAT_LEN + 1);
    localparam int unsigned CW     = 4 * DIGITS;
    localparam int unsigned NEW_SH = IDX_W * (PAT_LEN - 1);

    logic [HW-1:0]     hist, hist_nxt;
    logic [FILL_W-1:0] fill, fill_nxt;
    logic [CW-1:0]     cnt_q, cnt_nxt;
    logic              c1_q, c2_q, c2_nxt, err_q, err_nxt;

    logic [IDX_W-1:0]  sym_idx;
    logic              legal, illegal, match, carry;
    logic [3:0]        dig;

    // One-hot classification and index encode
    always_comb begin
        sym_idx = '0;
        legal   = (sym != '0) && ((sym & (sym - N_SYM'(1))) == '0);
        illegal = (sym != '0) && !legal;
        for (int i = 0; i < N_SYM; i++) begin
            if (sym[i]) sym_idx = IDX_W'(i);
        end
    end

    // Next-state: history shift (newest symbol at the top slice), match, BCD count, sticky flags
    always_comb begin
        hist_nxt = hist;
        fill_nxt = fill;
        cnt_nxt  = cnt_q;
        c2_nxt   = c2_q;
        err_nxt  = err_q;
        match    = 1'b0;
        carry    = 1'b0;
        dig      = '0;

        if (illegal) begin
            hist_nxt = '0;
            fill_nxt = '0;
            err_nxt  = 1'b1;
        end else if (legal) begin
            hist_nxt = (hist >> IDX_W) | (HW'(sym_idx) << NEW_SH);
            fill_nxt = (fill == FILL_W'(PAT_LEN)) ? fill : fill + FILL_W'(1);
            match    = (fill_nxt == FILL_W'(PAT_LEN)) && (hist_nxt == PATTERN);
        end

`ifdef SEQ_OVERLAP_EN
`else
        if (match) fill_nxt = '0;
`endif

        carry = match;
        for (int d = 0; d < DIGITS; d++) begin
            dig = cnt_q[4*d +: 4];
            if (carry) begin
                if (dig == 4'd9) begin
                    dig = 4'd0;
                end else begin
                    dig   = dig + 4'd1;
                    carry = 1'b0;
                end
            end
            cnt_nxt[4*d +: 4] = dig;
        end
        if (carry) c2_nxt = 1'b1;

        // Clear dominates count and overflow; an illegal symbol on the same edge is still recorded
        if (clr) begin
            cnt_nxt = '0;
            c2_nxt  = 1'b0;
            err_nxt = illegal;
        end
    end

    always_ff @(posedge ck or negedge rs) begin
        if (!rs) begin
            hist  <= '0;
            fill  <= '0;
            cnt_q <= '0;
            c1_q  <= 1'b0;
            c2_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            hist  <= hist_nxt;
            fill  <= fill_nxt;
            cnt_q <= cnt_nxt;
            c1_q  <= match;
            c2_q  <= c2_nxt;
            err_q <= err_nxt;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    // Segment decode straight off the registered count
    always_comb begin
        p = '0;
        for (int d = 0; d < DIGITS; d++) begin
            p[7*d +: 7] = seg7(cnt_q[4*d +: 4]);
        end
    end

    assign cnt = cnt_q;
    assign c1  = c1_q;
    assign c2  = c2_q;
    assign err = err_q;

endmodule

// File: tb/tb_seq_match_display.sv
// Directed bench for seq_match_display at default parameters (pattern a,b,a; two BCD digits).
module tb_seq_match_display;

    logic        ck;
    logic        rs;
    logic [2:0]  sym;
    logic        clr;
    logic [13:0] p;
    logic [7:0]  cnt;
    logic        c1, c2, err;

    int checks = 0;
    int errors = 0;

`ifdef SEQ_OVERLAP_EN
    localparam bit OV = 1'b1;
`else
    localparam bit OV = 1'b0;
`endif

    localparam logic [2:0] SA = 3'b001;
    localparam logic [2:0] SB = 3'b010;
    localparam logic [2:0] SI = 3'b000;

    seq_match_display dut (
        .ck  (ck),
        .rs  (rs),
        .sym (sym),
        .clr (clr),
        .p   (p),
        .cnt (cnt),
        .c1  (c1),
        .c2  (c2),
        .err (err)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one symbol across a rising edge and leave outputs settled for sampling
    task automatic cyc(input logic [2:0] s, input logic cl);
        sym = s;
        clr = cl;
        @(posedge ck);
        #1;
        sym = SI;
        clr = 1'b0;
    endtask

    task automatic flush();
        cyc(3'b011, 1'b0);
        check("flush_err", 32'(err), 32'd1);
        cyc(SI, 1'b1);
        check("flush_cnt", 32'(cnt), 32'h00);
        check("flush_err_clr", 32'(err), 32'd0);
    endtask

    function automatic logic [7:0] bcd(input int n);
        return 8'(((n / 10) % 10) * 16 + (n % 10));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rs  = 1'b0;
        sym = SI;
        clr = 1'b0;
        #12;
        check("rst_cnt", 32'(cnt), 32'h00);
        check("rst_c1", 32'(c1), 32'd0);
        check("rst_c2", 32'(c2), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_p", 32'(p), 32'h1FBF);
        #1 rs = 1'b1;
        @(posedge ck);
        #1;
        check("rel_cnt", 32'(cnt), 32'h00);
        check("rel_p", 32'(p), 32'h1FBF);

        // a,b,a,b,a
        cyc(SA, 1'b0); check("ov_c1_1", 32'(c1), 32'd0);
        cyc(SB, 1'b0); check("ov_c1_2", 32'(c1), 32'd0);
        cyc(SA, 1'b0); check("ov_c1_3", 32'(c1), 32'd1);
        check("ov_cnt_3", 32'(cnt), 32'h01);
        check("ov_p_3", 32'(p), 32'h1F86);
        cyc(SB, 1'b0); check("ov_c1_4", 32'(c1), 32'd0);
        cyc(SA, 1'b0); check("ov_c1_5", 32'(c1), 32'(OV));
        check("ov_cnt_5", 32'(cnt), OV ? 32'h02 : 32'h01);
        flush();

        // a,idle,b,idle,idle,a
        cyc(SA, 1'b0); check("gap_c1_1", 32'(c1), 32'd0);
        cyc(SI, 1'b0); check("gap_c1_2", 32'(c1), 32'd0);
        cyc(SB, 1'b0); check("gap_c1_3", 32'(c1), 32'd0);
        cyc(SI, 1'b0); check("gap_c1_4", 32'(c1), 32'd0);
        cyc(SI, 1'b0); check("gap_c1_5", 32'(c1), 32'd0);
        cyc(SA, 1'b0); check("gap_c1_6", 32'(c1), 32'd1);
        check("gap_cnt", 32'(cnt), 32'h01);
        cyc(SI, 1'b0); check("gap_c1_pulse", 32'(c1), 32'd0);
        flush();

        // a,b,110,a,b,a
        cyc(SA, 1'b0);
        cyc(SB, 1'b0);
        cyc(3'b110, 1'b0); check("ill_c1", 32'(c1), 32'd0);
        check("ill_err", 32'(err), 32'd1);
        cyc(SA, 1'b0); check("ill_c1_a", 32'(c1), 32'd0);
        cyc(SB, 1'b0); check("ill_c1_b", 32'(c1), 32'd0);
        cyc(SA, 1'b0); check("ill_match", 32'(c1), 32'd1);
        check("ill_cnt", 32'(cnt), 32'h01);
        check("ill_err_kept", 32'(err), 32'd1);
        cyc(SI, 1'b1);
        check("ill_clr_cnt", 32'(cnt), 32'h00);
        check("ill_clr_err", 32'(err), 32'd0);
        check("ill_clr_c1", 32'(c1), 32'd0);

        // 100 matches: BCD carry, wrap and overflow flag
        for (int i = 1; i <= 100; i++) begin
            cyc(SA, 1'b0);
            cyc(SB, 1'b0);
            cyc(SA, 1'b0);
            check("of_c1", 32'(c1), 32'd1);
            check("of_cnt", 32'(cnt), 32'(bcd(i % 100)));
            if (i == 99) begin
                check("of_p_99", 32'(p), 32'h37EF);
                check("of_c2_99", 32'(c2), 32'd0);
            end
            if (i == 100) begin
                check("of_c2_100", 32'(c2), 32'd1);
                check("of_p_100", 32'(p), 32'h1FBF);
            end
        end
        cyc(SA, 1'b0);
        cyc(SB, 1'b0);
        cyc(SA, 1'b1);
        check("clrm_c1", 32'(c1), 32'd1);
        check("clrm_cnt", 32'(cnt), 32'h00);
        check("clrm_c2", 32'(c2), 32'd0);

        // reset between edges mid-pattern
        cyc(SA, 1'b0);
        cyc(SB, 1'b0);
        #2 rs = 1'b0;
        #1;
        check("mid_async_cnt", 32'(cnt), 32'h00);
        #2 rs = 1'b1;
        cyc(SA, 1'b0); check("mid_no_c1", 32'(c1), 32'd0);
        cyc(SA, 1'b0);
        cyc(SB, 1'b0);
        cyc(SA, 1'b0); check("mid_c1", 32'(c1), 32'd1);
        check("mid_cnt", 32'(cnt), 32'h01);
        check("mid_err", 32'(err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
